// File: rtl/uart_rx.sv
// 8N1 serial receiver with a 2-flop input synchroniser and mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 frames and the extra parity_err output.
module uart_rx #(
    parameter int CLOCK_RATE_HZ   = 100_000_000,
    parameter int BAUD_RATE_HZ    = 10_000_000,
    parameter int CLOCKS_PER_BAUD = CLOCK_RATE_HZ / BAUD_RATE_HZ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [31:0] HALF_M1 = 32'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [31:0] FULL_M1 = 32'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_meta;
    logic        rx_s;
    logic [31:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        sample;
    logic        stop_ok;
    logic        stop_bad;
`ifdef UART_RX_PARITY_EN
    logic        par_bit;
`endif

    // Synchroniser resets high so a reset looks like an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Start bit is checked at its middle; every later bit one full bit after that.
    always_comb begin
        case (state)
            S_START:                 sample = (baud_cnt == HALF_M1);
            S_DATA, S_PARITY, S_STOP: sample = (baud_cnt == FULL_M1);
            default:                 sample = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || sample || state == S_IDLE || state == S_BREAK)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 32'd1;
            if (state != S_DATA)
                bit_cnt <= '0;
            else if (sample)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!rx_s) state_nxt = S_START;
            S_START:  if (sample) state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (sample && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
            S_PARITY: if (sample) state_nxt = S_STOP;
            S_STOP:   if (sample) state_nxt = rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx_s) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        stop_ok  = (state == S_STOP) && sample && rx_s;
        stop_bad = (state == S_STOP) && sample && !rx_s;
    end

    // Bits enter at the MSB side so the first (LSB) bit ends up in shift[0].
    always_ff @(posedge clk) begin
        if (state == S_DATA && sample)
            shift <= {rx_s, shift[7:1]};
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (state == S_PARITY && sample)
            par_bit <= rx_s;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            valid     <= stop_ok;
            frame_err <= stop_bad;
            if (stop_ok)
                data <= shift;
`ifdef UART_RX_PARITY_EN
            parity_err <= stop_ok && (^{shift, par_bit});
`endif
        end
    end

endmodule
